// File: rtl/row_buf_pingpong.sv
// Two-slot ping-pong row register between operand fetch and the MAC array.
// Each row is drained either as one parallel beat or lane by lane, lane 0 first.
module row_buf_pingpong #(
    parameter  int W  = 16,
    parameter  int N  = 10,
    localparam int LW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_ser,
    input  logic [N*W-1:0]  din,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_ser,
    output logic            out_last,
    output logic [LW-1:0]   out_lane,
    output logic [N*W-1:0]  dout,
    output logic [1:0]      count
);

    logic [N*W-1:0] bank_q [2];
    logic [N*W-1:0] bank_d [2];
    logic [1:0]     mode_q;
    logic [1:0]     mode_d;
    logic           wr_ptr_q, wr_ptr_d;
    logic           rd_ptr_q, rd_ptr_d;
    logic [1:0]     count_q, count_d;
    logic [LW-1:0]  lane_q, lane_d;

    logic [N*W-1:0] head_row;
    logic [W-1:0]   head_lane;
    logic           head_ser;
    logic           lane_last;
    logic           push;
    logic           beat;
    logic           pop;

    // Everything visible at the outputs is decoded from stored state only.
    always_comb begin
        head_row  = bank_q[rd_ptr_q];
        head_ser  = mode_q[rd_ptr_q];
        head_lane = head_row[int'(lane_q)*W +: W];
        lane_last = (lane_q == LW'(N - 1));

        in_ready  = (count_q != 2'd2);
        out_valid = (count_q != 2'd0);
        count     = count_q;
        out_ser   = out_valid && head_ser;
        out_last  = out_valid && (!head_ser || lane_last);
        out_lane  = (out_valid && head_ser) ? lane_q : '0;
        dout      = '0;
        if (out_valid) begin
            if (head_ser) begin
                dout[W-1:0] = head_lane;
            end else begin
                dout = head_row;
            end
        end
    end

    always_comb begin
        push = in_valid && in_ready;
        beat = out_valid && out_ready;
        pop  = beat && (!head_ser || lane_last);

        bank_d   = bank_q;
        mode_d   = mode_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        lane_d   = lane_q;

        if (reset) begin
            bank_d[0] = '0;
            bank_d[1] = '0;
            mode_d    = '0;
            wr_ptr_d  = 1'b0;
            rd_ptr_d  = 1'b0;
            count_d   = 2'd0;
            lane_d    = '0;
        end else if (flush) begin
            // Bank contents survive a flush; they are simply no longer counted.
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
            lane_d   = '0;
        end else begin
            if (push) begin
                bank_d[wr_ptr_q] = din;
                mode_d[wr_ptr_q] = in_ser;
                wr_ptr_d         = !wr_ptr_q;
            end
            if (beat && head_ser) begin
                lane_d = lane_last ? '0 : lane_q + LW'(1);
            end
            if (pop) begin
                rd_ptr_d = !rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(negedge CLK) begin
        bank_q   <= bank_d;
        mode_q   <= mode_d;
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
        lane_q   <= lane_d;
    end

endmodule
